// File: rtl/gated_ff_array_if.sv
// Stream bus for gated_ff_array: input beat, output beat, and the optional
// handshake count (present only when GATED_FF_ARRAY_COUNT_EN is defined).
interface gated_ff_array_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [1:0]       MODE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] O;
  logic             OUT_VALID;
  logic             OUT_READY;
`ifdef GATED_FF_ARRAY_COUNT_EN
  logic [15:0]      CNT;
`endif

  modport master (
`ifdef GATED_FF_ARRAY_COUNT_EN
    input  CNT,
`endif
    output I0, I1, MODE, IN_VALID, OUT_READY,
    input  IN_READY, O, OUT_VALID
  );

  modport slave (
`ifdef GATED_FF_ARRAY_COUNT_EN
    output CNT,
`endif
    input  I0, I1, MODE, IN_VALID, OUT_READY,
    output IN_READY, O, OUT_VALID
  );
endinterface

// File: rtl/gated_ff_array.sv
// WIDTH lanes of a mode-selectable 2-input gate feeding a DEPTH-stage
// valid/ready pipeline. GATED_FF_ARRAY_COUNT_EN adds a 16-bit output beat counter.
module gated_ff_lane (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] mode_i,
  output logic       y_o
);
  always_comb begin
    y_o = 1'b0;
    unique case (mode_i)
      2'b00: y_o = a_i & b_i;
      2'b01: y_o = a_i | b_i;
      2'b10: y_o = a_i ^ b_i;
      2'b11: y_o = ~(a_i & b_i);
      default: y_o = 1'b0;
    endcase
  end
endmodule

module gated_ff_array #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  gated_ff_array_if.slave bus
);
  logic [WIDTH-1:0]             gate_w;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             adv;
  logic                         in_fire;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    gated_ff_lane u_lane (
      .a_i    (bus.I0[g]),
      .b_i    (bus.I1[g]),
      .mode_i (bus.MODE),
      .y_o    (gate_w[g])
    );
  end

  // Ready ripples back from the output: a stage may load if it is empty or
  // its own content moves on this cycle, so a full pipe still streams.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~vld_q[DEPTH-1] | bus.OUT_READY;
    for (int k = DEPTH-2; k >= 0; k--)
      adv[k] = ~vld_q[k] | adv[k+1];
  end

  assign in_fire = bus.IN_VALID & adv[0];

  // Data only loads alongside a valid source so O keeps its last beat when empty.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv[0]) begin
      vld_d[0] = in_fire;
      if (in_fire) data_d[0] = gate_w;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign bus.IN_READY  = adv[0];
  assign bus.O         = data_q[DEPTH-1];
  assign bus.OUT_VALID = vld_q[DEPTH-1];

`ifdef GATED_FF_ARRAY_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (vld_q[DEPTH-1] & bus.OUT_READY) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.CNT = cnt_q;
`endif
endmodule

// File: tb/tb_gated_ff_array.sv
// Scoreboard bench for gated_ff_array (WIDTH=2, DEPTH=2); the count scenario
// runs only when GATED_FF_ARRAY_COUNT_EN is defined.
module tb_gated_ff_array;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [1:0] sb[$];

  gated_ff_array_if #(.WIDTH(2)) bus ();

  gated_ff_array #(.WIDTH(2), .DEPTH(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] gate_model(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] m);
    case (m)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // One clock: sample handshakes mid-cycle, push accepted beats, step past the edge.
  task automatic tick(output logic fired, output logic [1:0] odata, output logic accepted);
    @(negedge clk);
    accepted = !rst && bus.IN_VALID && bus.IN_READY;
    fired    = !rst && bus.OUT_VALID && bus.OUT_READY;
    odata    = bus.O;
    if (accepted) sb.push_back(gate_model(bus.I0, bus.I1, bus.MODE));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IN_VALID = 1'b0;
    bus.I0 = '0;
    bus.I1 = '0;
    bus.MODE = 2'b00;
  endtask

  task automatic test_reset();
    logic f, a;
    logic [1:0] d;
    rst = 1'b1;
    idle_inputs();
    bus.OUT_READY = 1'b0;
    tick(f, d, a);
    tick(f, d, a);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (bus.O !== 2'b00) begin errors++; $display("FAIL reset_O got=%b exp=00", bus.O); end
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_OUT_VALID got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_IN_READY got=%b exp=1", bus.IN_READY); end
  endtask

  task automatic test_single_beat();
    logic f, a;
    logic [1:0] d, e;
    bus.OUT_READY = 1'b1;
    bus.MODE = 2'b00; bus.I0 = 2'b11; bus.I1 = 2'b01; bus.IN_VALID = 1'b1;
    tick(f, d, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", a); end
    idle_inputs();
    tick(f, d, a);
    checks++;
    if (f !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", f); end
    tick(f, d, a);
    checks++;
    if (f !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", f); end
    else begin
      e = sb.pop_front();
      checks++;
      if (d !== e || d !== 2'b01) begin errors++; $display("FAIL single_data got=%b exp=%b", d, e); end
    end
    tick(f, d, a);
    checks++;
    if (f !== 1'b0 || bus.O !== 2'b01) begin
      errors++; $display("FAIL single_once valid=%b O=%b exp valid=0 O=01", f, bus.O);
    end
  endtask

  task automatic test_mode_sweep();
    logic f, a;
    logic [1:0] d, e;
    logic [1:0] want [4];
    int n, first, last;
    want = '{2'b10, 2'b11, 2'b01, 2'b01};
    n = 0; first = -1; last = -1;
    bus.OUT_READY = 1'b1;
    bus.I0 = 2'b10; bus.I1 = 2'b11;
    for (int c = 0; c < 12 && n < 4; c++) begin
      if (c < 4) begin bus.IN_VALID = 1'b1; bus.MODE = c[1:0]; end
      else idle_inputs();
      tick(f, d, a);
      if (f) begin
        e = sb.pop_front();
        checks++;
        if (d !== e || d !== want[n]) begin
          errors++; $display("FAIL sweep_data[%0d] got=%b exp=%b", n, d, want[n]);
        end
        if (first < 0) first = c;
        last = c; n++;
      end
    end
    idle_inputs();
    checks++;
    if (n != 4 || last - first != 3) begin
      errors++; $display("FAIL sweep_consecutive beats=%0d span=%0d exp beats=4 span=3", n, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic f, a;
    logic [1:0] d, e;
    int idx, nacc, nout;
    idx = 0; nacc = 0; nout = 0;
    bus.OUT_READY = 1'b0;
    bus.MODE = 2'b01; bus.I1 = 2'b00; bus.IN_VALID = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.I0 = idx[1:0];
      tick(f, d, a);
      if (a) begin idx++; nacc++; end
    end
    checks++;
    if (nacc != 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", nacc); end
    checks++;
    if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1) begin
      errors++; $display("FAIL bp_full IN_READY=%b OUT_VALID=%b exp 0/1", bus.IN_READY, bus.OUT_VALID);
    end
    for (int c = 0; c < 3; c++) begin
      bus.I0 = idx[1:0];
      tick(f, d, a);
      checks++;
      if (d !== 2'b00 || a) begin errors++; $display("FAIL bp_stable O=%b acc=%b exp O=00 acc=0", d, a); end
    end
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 20 && nout < 4; c++) begin
      if (idx < 4) begin bus.IN_VALID = 1'b1; bus.I0 = idx[1:0]; end
      else idle_inputs();
      tick(f, d, a);
      if (a) idx++;
      if (f) begin
        e = sb.pop_front();
        checks++;
        if (d !== e || d !== nout[1:0]) begin
          errors++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", nout, d, nout);
        end
        nout++;
      end
    end
    idle_inputs();
    checks++;
    if (nout != 4) begin errors++; $display("FAIL bp_drain beats=%0d exp=4", nout); end
  endtask

  task automatic test_full_drain();
    logic f, a;
    logic [1:0] d, e;
    bus.OUT_READY = 1'b0;
    bus.MODE = 2'b10; bus.IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.I0 = 2'($urandom); bus.I1 = 2'($urandom);
      tick(f, d, a);
    end
    checks++;
    if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL fd_full IN_READY=%b exp=0", bus.IN_READY); end
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.I0 = 2'($urandom); bus.I1 = 2'($urandom); bus.MODE = 2'($urandom);
      tick(f, d, a);
      checks++;
      if (!a || !f) begin errors++; $display("FAIL fd_stream[%0d] acc=%b out=%b exp 1/1", c, a, f); end
      if (f) begin
        e = sb.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL fd_data[%0d] got=%b exp=%b", c, d, e); end
      end
    end
    idle_inputs();
    for (int c = 0; c < 6 && sb.size() > 0; c++) begin
      tick(f, d, a);
      if (f) begin
        e = sb.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL fd_tail got=%b exp=%b", d, e); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL fd_left beats=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    logic f, a;
    logic [1:0] d;
    int nout;
    nout = 0;
    bus.OUT_READY = 1'b0;
    bus.MODE = 2'b01; bus.I0 = 2'b11; bus.I1 = 2'b00; bus.IN_VALID = 1'b1;
    tick(f, d, a);
    tick(f, d, a);
    rst = 1'b1; bus.OUT_READY = 1'b1;
    tick(f, d, a);
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.O !== 2'b00 || bus.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid OUT_VALID=%b O=%b IN_READY=%b exp 0/00/1", bus.OUT_VALID, bus.O, bus.IN_READY);
    end
    for (int c = 0; c < 4; c++) begin
      tick(f, d, a);
      if (f) nout++;
    end
    checks++;
    if (nout != 0) begin errors++; $display("FAIL rst_ghost beats=%0d exp=0", nout); end
  endtask

`ifdef GATED_FF_ARRAY_COUNT_EN
  task automatic test_count();
    logic f, a;
    logic [1:0] d, e;
    int nout;
    nout = 0;
    rst = 1'b1;
    tick(f, d, a);
    rst = 1'b0;
    sb.delete();
    bus.OUT_READY = 1'b1;
    bus.IN_VALID = 1'b1; bus.MODE = 2'b00; bus.I0 = 2'b11; bus.I1 = 2'b11;
    for (int c = 0; c < 70000 && nout < 65537; c++) begin
      if (nout >= 65537 - 2) bus.IN_VALID = 1'b0;
      tick(f, d, a);
      if (f) begin e = sb.pop_front(); nout++; end
    end
    idle_inputs();
    checks++;
    if (nout != 65537 || bus.CNT !== 16'd1) begin
      errors++; $display("FAIL cnt_wrap beats=%0d CNT=%0d exp beats=65537 CNT=1", nout, bus.CNT);
    end
    rst = 1'b1;
    tick(f, d, a);
    rst = 1'b0;
    checks++;
    if (bus.CNT !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", bus.CNT); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.I0 = '0;
    bus.I1 = '0;
    bus.MODE = '0;
    test_reset();
    test_single_beat();
    test_mode_sweep();
    test_backpressure();
    test_full_drain();
    test_reset_midflight();
`ifdef GATED_FF_ARRAY_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
